display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller_pkg.sv | 41 ++++
 rtl/display_scan_controller_if.sv | 30 +++
 rtl/display_scan_controller_scan_timer.sv | 38 +++
 rtl/display_scan_controller.sv | 123 ++++++++++++
 tb/tb_display_scan_controller.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_scan_controller_pkg                                        |
// | Shared types, constants and digit helpers for the scan controller. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package display_scan_controller_pkg;

    localparam int NUM_DIGITS = 6;
    localparam logic [NUM_DIGITS-1:0] c_ANODES_OFF = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    function automatic logic [3:0] digit_code(
        input logic [4*NUM_DIGITS-1:0] shadow,
        input logic [2:0]              idx
    );
        logic [4*NUM_DIGITS-1:0] w_shifted;
        w_shifted = shadow >> (4 * idx);
        return w_shifted[3:0];
    endfunction

    // Suppressed when the code is not decimal, or when blanking is on and this
    // digit and everything above it are zero (digit 0 always stays visible).
    function automatic logic digit_suppressed(
        input logic [4*NUM_DIGITS-1:0] shadow,
        input logic [2:0]              idx,
        input logic                    lzb_en
    );
        logic [4*NUM_DIGITS-1:0] w_upper;
        w_upper = shadow >> (4 * idx);
        return (w_upper[3:0] > 4'd9) ||
               (lzb_en && (idx != 3'd0) && (w_upper == '0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_scan_controller_if                                         |
// | Control, data and display-drive signals of the scan controller.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface display_scan_controller_if;
    import display_scan_controller_pkg::*;

    logic                    enable;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    lzb_en;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   digit_sel_n;
    logic                    load_ack;
    logic                    frame_done;

    modport master (
        output enable, digits_in, load, lzb_en,
        input  bcd_out, digit_sel_n, load_ack, frame_done
    );

    modport slave (
        input  enable, digits_in, load, lzb_en,
        output bcd_out, digit_sel_n, load_ack, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/display_scan_controller_scan_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_timer                                                         |
// | Loadable down-counter; o_tc pulses once when a loaded count ends.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module scan_timer #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_value,
    output logic                  o_tc
);

    logic [WIDTH-1:0] r_count;
    logic             r_running;

    // A loaded value N gives a terminal pulse on the (N+1)th cycle after the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (i_load) begin
            r_count   <= i_load_value;
            r_running <= 1'b1;
        end else if (r_count != '0) begin
            r_count   <= r_count - 1'b1;
        end else begin
            r_running <= 1'b0;
        end
    end

    assign o_tc = r_running && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_scan_controller                                            |
// | Six-digit multiplexed BCD display scanner with blanking gaps.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    display_scan_controller_if.slave   disp_if
);

    localparam int c_MAX_LOAD = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int c_TW       = (c_MAX_LOAD > 1) ? $clog2(c_MAX_LOAD) : 1;
    localparam logic [c_TW-1:0] c_SHOW_LOAD = c_TW'(CLK_DIV - 1);
    localparam logic [c_TW-1:0] c_GAP_LOAD  = c_TW'(BLANK_CYCLES - 1);
    localparam logic [2:0]      c_LAST_IDX  = 3'(NUM_DIGITS - 1);

    scan_state_t             r_state, w_state_nxt;
    logic [2:0]              r_index, w_index_nxt;
    logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_nxt;
    logic                    r_pending, w_pending_nxt;
    logic                    w_capture, w_wrap;
    logic                    w_tmr_load, w_tc;
    logic [c_TW-1:0]         w_tmr_value;

    logic [3:0]              r_bcd;
    logic [NUM_DIGITS-1:0]   r_sel_n;
    logic                    r_load_ack, r_frame_done;

    scan_timer #(.WIDTH(c_TW)) u_scan_timer (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .o_tc         (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_tmr_load  = 1'b0;
        w_tmr_value = c_SHOW_LOAD;
        w_wrap      = 1'b0;
        if (!disp_if.enable) begin
            w_state_nxt = IDLE;
            w_index_nxt = 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SHOW;
                    w_index_nxt = 3'd0;
                    w_tmr_load  = 1'b1;
                end
                SHOW: if (w_tc) begin
                    w_state_nxt = GAP;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_GAP_LOAD;
                end
                GAP: if (w_tc) begin
                    w_state_nxt = SHOW;
                    w_tmr_load  = 1'b1;
                    if (r_index == c_LAST_IDX) begin
                        w_index_nxt = 3'd0;
                        w_wrap      = 1'b1;
                    end else begin
                        w_index_nxt = r_index + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_index_nxt = 3'd0;
                end
            endcase
        end
        // A load on the capture cycle itself is consumed by that capture.
        w_capture     = (disp_if.load || r_pending) && ((r_state == IDLE) || w_wrap);
        w_pending_nxt = !w_capture && (r_pending || disp_if.load);
        w_shadow_nxt  = w_capture ? disp_if.digits_in : r_shadow;
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_index      <= 3'd0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_bcd        <= 4'h0;
            r_sel_n      <= c_ANODES_OFF;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pending    <= w_pending_nxt;
            r_load_ack   <= w_capture;
            r_frame_done <= w_wrap;
            if (w_state_nxt == SHOW) begin
                r_bcd <= digit_code(w_shadow_nxt, w_index_nxt);
                if (digit_suppressed(w_shadow_nxt, w_index_nxt, disp_if.lzb_en))
                    r_sel_n <= c_ANODES_OFF;
                else
                    r_sel_n <= c_ANODES_OFF & ~(NUM_DIGITS'(1) << w_index_nxt);
            end else begin
                r_sel_n <= c_ANODES_OFF;
            end
        end
    end

    assign disp_if.bcd_out     = r_bcd;
    assign disp_if.digit_sel_n = r_sel_n;
    assign disp_if.load_ack    = r_load_ack;
    assign disp_if.frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_display_scan_controller                                         |
// | Directed self-checking bench, CLK_DIV=4 and BLANK_CYCLES=2.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_display_scan_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n;
    int   multi_low;
    int   early_ack;

    always #5 clk = ~clk;

    display_scan_controller_if bus ();

    display_scan_controller #(
        .CLK_DIV      (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .disp_if (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_fd(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (bus.frame_done !== 1'b1 && cnt < budget);
    endtask

    function automatic int zeros(input logic [5:0] v);
        int z = 0;
        for (int i = 0; i < 6; i++) if (v[i] === 1'b0) z++;
        return z;
    endfunction

    initial begin
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.lzb_en    = 1'b0;
        bus.digits_in = 24'h000000;
        tick(3);
        chk("rst_sel", 32'(bus.digit_sel_n), 32'h3f);
        chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
        chk("rst_ack", 32'(bus.load_ack), 32'h0);
        chk("rst_fd", 32'(bus.frame_done), 32'h0);

        // Load in IDLE, then first two slots
        reset = 1'b0; bus.enable = 1'b1; bus.load = 1'b1; bus.digits_in = 24'h123456;
        tick(1);
        bus.load = 1'b0;
        chk("ack_idle", 32'(bus.load_ack), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("slot0_sel", 32'(bus.digit_sel_n), 32'h3e);
            chk("slot0_bcd", 32'(bus.bcd_out), 32'h6);
            tick(1);
        end
        chk("gap1_sel", 32'(bus.digit_sel_n), 32'h3f);
        chk("gap1_bcd_hold", 32'(bus.bcd_out), 32'h6);
        chk("ack_once", 32'(bus.load_ack), 32'h0);
        tick(1);
        chk("gap2_sel", 32'(bus.digit_sel_n), 32'h3f);
        tick(1);
        chk("slot1_sel", 32'(bus.digit_sel_n), 32'h3d);
        chk("slot1_bcd", 32'(bus.bcd_out), 32'h5);

        // Free-run frame period
        wait_fd(60, n);
        chk("first_fd_wait", 32'(n), 32'd30);
        multi_low = 0;
        n = 0;
        do begin
            tick(1);
            n++;
            if (zeros(bus.digit_sel_n) > 1) multi_low++;
        end while (bus.frame_done !== 1'b1 && n < 60);
        chk("frame_period", 32'(n), 32'd36);
        chk("multi_low", 32'(multi_low), 32'd0);
        chk("fd_slot0_sel", 32'(bus.digit_sel_n), 32'h3e);

        // Mid-frame load at index 2 waits for the wrap
        tick(12);
        chk("slot2_sel", 32'(bus.digit_sel_n), 32'h3b);
        chk("slot2_bcd", 32'(bus.bcd_out), 32'h4);
        bus.load = 1'b1; bus.digits_in = 24'h999999;
        tick(1);
        bus.load = 1'b0;
        tick(5);
        chk("shadow_hold_bcd", 32'(bus.bcd_out), 32'h3);
        chk("shadow_hold_sel", 32'(bus.digit_sel_n), 32'h37);
        early_ack = 0;
        n = 0;
        do begin
            tick(1);
            n++;
            if (bus.load_ack === 1'b1 && bus.frame_done !== 1'b1) early_ack++;
        end while (bus.frame_done !== 1'b1 && n < 40);
        chk("wrap_wait", 32'(n), 32'd18);
        chk("early_ack", 32'(early_ack), 32'd0);
        chk("ack_with_fd", 32'(bus.load_ack), 32'h1);
        chk("new_shadow_bcd", 32'(bus.bcd_out), 32'h9);

        // Leading-zero blanking
        bus.load = 1'b1; bus.lzb_en = 1'b1; bus.digits_in = 24'h000070;
        tick(1);
        bus.load = 1'b0;
        wait_fd(40, n);
        chk("lzb_wait", 32'(n), 32'd35);
        chk("lzb_ack", 32'(bus.load_ack), 32'h1);
        chk("lzb_d0_sel", 32'(bus.digit_sel_n), 32'h3e);
        chk("lzb_d0_bcd", 32'(bus.bcd_out), 32'h0);
        tick(6);
        chk("lzb_d1_sel", 32'(bus.digit_sel_n), 32'h3d);
        chk("lzb_d1_bcd", 32'(bus.bcd_out), 32'h7);
        tick(6);
        chk("lzb_d2_sel", 32'(bus.digit_sel_n), 32'h3f);
        tick(18);
        chk("lzb_d5_sel", 32'(bus.digit_sel_n), 32'h3f);
        bus.lzb_en = 1'b0;
        tick(1);
        chk("nolzb_d5_sel", 32'(bus.digit_sel_n), 32'h1f);
        tick(5);
        chk("nolzb_fd", 32'(bus.frame_done), 32'h1);
        chk("nolzb_d0_sel", 32'(bus.digit_sel_n), 32'h3e);
        tick(12);
        chk("nolzb_d2_sel", 32'(bus.digit_sel_n), 32'h3b);
        chk("nolzb_d2_bcd", 32'(bus.bcd_out), 32'h0);

        // Non-decimal digit in slot 3
        bus.load = 1'b1; bus.digits_in = 24'h00B000;
        tick(1);
        bus.load = 1'b0;
        wait_fd(40, n);
        chk("hex_ack", 32'(bus.load_ack), 32'h1);
        tick(18);
        chk("hex_d3_sel", 32'(bus.digit_sel_n), 32'h3f);
        chk("hex_d3_bcd", 32'(bus.bcd_out), 32'hb);
        tick(6);
        chk("hex_d4_sel", 32'(bus.digit_sel_n), 32'h2f);

        // Enable drop during SHOW, restart, then reset mid-scan
        bus.enable = 1'b0;
        tick(1);
        chk("dis_sel", 32'(bus.digit_sel_n), 32'h3f);
        tick(2);
        chk("dis_idle_sel", 32'(bus.digit_sel_n), 32'h3f);
        bus.enable = 1'b1;
        tick(1);
        chk("restart_sel", 32'(bus.digit_sel_n), 32'h3e);
        chk("restart_bcd", 32'(bus.bcd_out), 32'h0);
        tick(12);
        chk("pre_rst_sel", 32'(bus.digit_sel_n), 32'h3b);
        reset = 1'b1; bus.load = 1'b1; bus.digits_in = 24'h555555;
        tick(1);
        chk("midrst_sel", 32'(bus.digit_sel_n), 32'h3f);
        chk("midrst_bcd", 32'(bus.bcd_out), 32'h0);
        chk("midrst_ack", 32'(bus.load_ack), 32'h0);
        reset = 1'b0; bus.load = 1'b0;
        tick(1);
        chk("postrst_sel", 32'(bus.digit_sel_n), 32'h3e);
        chk("postrst_ack", 32'(bus.load_ack), 32'h0);
        tick(18);
        chk("postrst_d3_sel", 32'(bus.digit_sel_n), 32'h37);
        chk("postrst_d3_bcd", 32'(bus.bcd_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
